// File: rtl/pipeline_run_ctrl_if.sv
// Data-memory address port shared by the CPU EX stage and the readout scanner.
//   cpu_addr   : EX-stage ALU result (CPU data address)
//   cpu_we     : CPU data-memory write strobe
//   mem_addr   : address presented to data memory
//   mem_we     : write strobe presented to data memory (gated)
//   scan_idx   : word index of the read data currently valid
//   scan_valid : memory read output corresponds to scan_idx
// master = the run controller, slave = the CPU/memory side.
interface pipeline_run_ctrl_if;
    logic [31:0] cpu_addr;
    logic        cpu_we;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [7:0]  scan_idx;
    logic        scan_valid;

    modport master (
        input  cpu_addr, cpu_we,
        output mem_addr, mem_we, scan_idx, scan_valid
    );

    modport slave (
        output cpu_addr, cpu_we,
        input  mem_addr, mem_we, scan_idx, scan_valid
    );
endinterface

// File: rtl/pipeline_run_ctrl.sv
// Run/step/breakpoint controller for the five-stage RISC-V pipeline.
// Generates the pipeline clock-enable, counts executed cycles, and hands the
// data-memory address port to a display scanner while the core is frozen.
//
// Ports:
//   clk, rst     : system clock, asynchronous active-low reset
//   run_req      : level, free-running execution request
//   step_req     : pulse, single pipeline advance request
//   halt_req     : level, stop execution / abort a scan
//   scan_req     : pulse, start a data-memory sweep
//   clr_count    : pulse, clear cycle_count (IDLE only)
//   bp_en, bp_pc : breakpoint enable and address
//   pc_in        : current IF-stage PC
//   mem          : data-memory port (cpu_addr/cpu_we in, mem_addr/mem_we/scan_* out)
//   cpu_clk_en   : pipeline advance enable
//   cycle_count  : saturating count of cycles with cpu_clk_en=1
//   state        : IDLE=0, RUN=1, STEP=2, SCAN=3
//   bp_hit       : sticky, last stop was caused by the breakpoint
module pipeline_run_ctrl #(
    parameter int SCAN_WORDS = 8,
    parameter int CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run_req,
    input  logic                 step_req,
    input  logic                 halt_req,
    input  logic                 scan_req,
    input  logic                 clr_count,
    input  logic                 bp_en,
    input  logic [31:0]          bp_pc,
    input  logic [31:0]          pc_in,
    pipeline_run_ctrl_if.master  mem,
    output logic                 cpu_clk_en,
    output logic [CNT_W-1:0]     cycle_count,
    output logic [1:0]           state,
    output logic                 bp_hit
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        SCAN = 2'd3
    } state_t;

    localparam logic [7:0] SCAN_LAST = 8'(SCAN_WORDS - 1);

    state_t           state_q;
    logic             first_run_q;
    logic [7:0]       scan_ptr_q;
    logic [7:0]       scan_idx_q;
    logic             scan_valid_q;
    logic [CNT_W-1:0] cycle_count_q;
    logic             bp_hit_q;

    logic             bp_match;
    logic             run_stop;

    // Counter holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // first_run masks the match on the cycle RUN is entered, so a core
    // frozen on the breakpoint PC can be resumed past it.
    assign bp_match = (state_q == RUN) && bp_en && (pc_in == bp_pc) && !first_run_q;
    assign run_stop = halt_req || !run_req || bp_match;

    // The stop cycle itself must not advance: the gate is combinational so
    // the core freezes with pc_in still at the breakpoint.
    assign cpu_clk_en = ((state_q == RUN) && !run_stop) || (state_q == STEP);

    assign mem.mem_addr   = (state_q == SCAN) ? {22'd0, scan_ptr_q, 2'b00} : mem.cpu_addr;
    assign mem.mem_we     = mem.cpu_we && cpu_clk_en;
    assign mem.scan_idx   = scan_idx_q;
    assign mem.scan_valid = scan_valid_q;

    assign cycle_count = cycle_count_q;
    assign state       = state_q;
    assign bp_hit      = bp_hit_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            first_run_q   <= 1'b0;
            scan_ptr_q    <= 8'd0;
            scan_idx_q    <= 8'd0;
            scan_valid_q  <= 1'b0;
            cycle_count_q <= '0;
            bp_hit_q      <= 1'b0;
        end else begin
            scan_valid_q <= 1'b0;
            if (cpu_clk_en) begin
                cycle_count_q <= sat_inc(cycle_count_q);
            end

            case (state_q)
                IDLE: begin
                    if (clr_count) begin
                        cycle_count_q <= '0;
                    end
                    if (halt_req) begin
                        state_q <= IDLE;
                    end else if (run_req) begin
                        state_q     <= RUN;
                        first_run_q <= 1'b1;
                        bp_hit_q    <= 1'b0;
                    end else if (step_req) begin
                        state_q  <= STEP;
                        bp_hit_q <= 1'b0;
                    end else if (scan_req) begin
                        state_q    <= SCAN;
                        scan_ptr_q <= 8'd0;
                    end
                end

                RUN: begin
                    first_run_q <= 1'b0;
                    if (bp_match) begin
                        bp_hit_q <= 1'b1;
                    end
                    if (run_stop) begin
                        state_q <= IDLE;
                    end
                end

                STEP: begin
                    state_q <= IDLE;
                end

                SCAN: begin
                    // Address issued this cycle returns data next cycle, so
                    // the index/valid pair trails scan_ptr by one. An abort
                    // suppresses the valid for the word in flight.
                    if (halt_req) begin
                        state_q <= IDLE;
                    end else begin
                        scan_valid_q <= 1'b1;
                        scan_idx_q   <= scan_ptr_q;
                        if (scan_ptr_q == SCAN_LAST) begin
                            state_q <= IDLE;
                        end else begin
                            scan_ptr_q <= scan_ptr_q + 8'd1;
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
module tb_pipeline_run_ctrl;

    localparam int SCAN_WORDS = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run_req = 1'b0;
    logic        step_req = 1'b0;
    logic        halt_req = 1'b0;
    logic        scan_req = 1'b0;
    logic        clr_count = 1'b0;
    logic        bp_en = 1'b0;
    logic [31:0] bp_pc = 32'd0;
    logic [31:0] pc_in = 32'd0;

    logic        cpu_clk_en, cpu_clk_en2;
    logic [31:0] cycle_count;
    logic [3:0]  cycle_count2;
    logic [1:0]  state, state2;
    logic        bp_hit, bp_hit2;

    pipeline_run_ctrl_if bus ();
    pipeline_run_ctrl_if bus2 ();

    assign bus2.cpu_addr = bus.cpu_addr;
    assign bus2.cpu_we   = bus.cpu_we;

    pipeline_run_ctrl #(.SCAN_WORDS(SCAN_WORDS), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .run_req(run_req), .step_req(step_req),
        .halt_req(halt_req), .scan_req(scan_req), .clr_count(clr_count),
        .bp_en(bp_en), .bp_pc(bp_pc), .pc_in(pc_in), .mem(bus),
        .cpu_clk_en(cpu_clk_en), .cycle_count(cycle_count), .state(state), .bp_hit(bp_hit)
    );

    // Narrow-counter instance for the saturation check.
    pipeline_run_ctrl #(.SCAN_WORDS(SCAN_WORDS), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .run_req(run_req), .step_req(step_req),
        .halt_req(halt_req), .scan_req(scan_req), .clr_count(clr_count),
        .bp_en(bp_en), .bp_pc(bp_pc), .pc_in(pc_in), .mem(bus2),
        .cpu_clk_en(cpu_clk_en2), .cycle_count(cycle_count2), .state(state2), .bp_hit(bp_hit2)
    );

    initial forever #5 clk = ~clk;

    // Synchronous-read data memory seen by the scanner.
    logic [31:0] dmem [0:255];
    logic [31:0] rdata = 32'd0;
    always @(posedge clk) rdata <= dmem[bus.mem_addr[9:2]];

    int vectors = 0;
    int errors  = 0;

    // Scoreboard queues filled by stimulus, drained by the monitor.
    logic [31:0] en_q [$];     // expected cycle_count on each enabled cycle
    logic [31:0] addr_q [$];   // expected mem_addr on each SCAN cycle
    logic [7:0]  sidx_q [$];   // expected scan_idx on each scan_valid cycle
    logic [31:0] sdat_q [$];   // expected memory data on each scan_valid cycle

    // Reference model state.
    logic [31:0] model_cnt = 32'd0;
    int          model_cnt4 = 0;
    logic        model_bp = 1'b0;
    logic [31:0] model_pc = 32'd0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Pipeline emulation: PC advances 4 per enabled cycle; CPU bus is random.
    logic en_s = 1'b0;
    initial begin
        bus.cpu_addr = 32'd0;
        bus.cpu_we   = 1'b0;
        forever begin
            @(negedge clk);
            en_s = cpu_clk_en;
            @(posedge clk);
            #2;
            if (en_s) pc_in = pc_in + 32'd4;
            bus.cpu_addr = $urandom;
            bus.cpu_we   = 1'($urandom);
        end
    end

    // Monitor.
    always @(negedge clk) begin
        if (rst) begin
            logic popped;
            logic [31:0] e;
            logic [7:0]  ei;
            popped = 1'b0;
            if (cpu_clk_en) begin
                if (en_q.size() == 0) begin
                    chk("unexpected_clk_en", 1, 0);
                end else begin
                    popped = 1'b1;
                    e = en_q.pop_front();
                    chk("cycle_count_on_en", cycle_count, e);
                end
            end
            chk("cpu_clk_en_narrow", cpu_clk_en2, popped);
            if (bus.cpu_we) chk("mem_we_gate", bus.mem_we, popped);
            if (state == 2'd3) begin
                if (addr_q.size() == 0) begin
                    chk("unexpected_scan_state", 1, 0);
                end else begin
                    e = addr_q.pop_front();
                    chk("scan_mem_addr", bus.mem_addr, e);
                end
            end else begin
                chk("cpu_mem_addr", bus.mem_addr, bus.cpu_addr);
            end
            if (bus.scan_valid) begin
                if (sidx_q.size() == 0) begin
                    chk("unexpected_scan_valid", 1, 0);
                end else begin
                    ei = sidx_q.pop_front();
                    e  = sdat_q.pop_front();
                    chk("scan_idx", bus.scan_idx, ei);
                    chk("scan_data", rdata, e);
                end
            end
        end
    end

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic add_en(input int n);
        for (int i = 0; i < n; i++) begin
            en_q.push_back(model_cnt);
            if (model_cnt != 32'hFFFF_FFFF) model_cnt++;
        end
        model_cnt4 = (model_cnt4 + n > 15) ? 15 : model_cnt4 + n;
        model_pc   = model_pc + 32'(4 * n);
    endtask

    task automatic end_check();
        chk("state_idle", state, 0);
        chk("cycle_count", cycle_count, model_cnt);
        chk("cycle_count_sat", cycle_count2, model_cnt4);
        chk("bp_hit", bp_hit, model_bp);
        chk("bp_hit_narrow", bp_hit2, model_bp);
        chk("pc_in", pc_in, model_pc);
        chk("en_left", en_q.size(), 0);
        chk("addr_left", addr_q.size(), 0);
        chk("scan_left", sidx_q.size(), 0);
        chk("state_narrow", state2, 0);
    endtask

    // Free run for n enabled cycles, optionally with a coincident scan_req
    // (run wins) and a clr_count during RUN (ignored).
    task automatic do_run(input int n, input logic with_scan, input logic with_clr);
        run_req  = 1'b1;
        scan_req = with_scan;
        add_en(n);
        model_bp = 1'b0;
        tick(1);
        scan_req  = 1'b0;
        clr_count = with_clr;
        tick(1);
        clr_count = 1'b0;
        tick(n - 1);
        run_req = 1'b0;
        tick(2);
        end_check();
    endtask

    // Run with breakpoint r words ahead; run_req held past the hit.
    task automatic do_bp(input int r);
        bp_en   = 1'b1;
        bp_pc   = model_pc + 32'(4 * r);
        run_req = 1'b1;
        add_en(r);
        model_bp = 1'b1;
        tick(r + 2);
        run_req = 1'b0;
        tick(2);
        chk("bp_freeze_pc", pc_in, bp_pc);
        end_check();
    endtask

    task automatic do_run_halt(input int j);
        run_req = 1'b1;
        add_en(j);
        model_bp = 1'b0;
        tick(j + 1);
        halt_req = 1'b1;
        tick(2);
        run_req  = 1'b0;
        halt_req = 1'b0;
        tick(2);
        end_check();
    endtask

    task automatic do_step(input logic extra);
        step_req = 1'b1;
        add_en(1);
        model_bp = 1'b0;
        tick(1);
        step_req = extra;
        tick(1);
        step_req = 1'b0;
        tick(2);
        end_check();
    endtask

    // halt_at = 0: full sweep; otherwise abort during the halt_at-th scan cycle.
    task automatic do_scan(input int halt_at);
        int n_addr, n_val;
        n_addr = (halt_at == 0) ? SCAN_WORDS : halt_at;
        n_val  = (halt_at == 0) ? SCAN_WORDS : halt_at - 1;
        for (int i = 0; i < n_addr; i++) addr_q.push_back(32'(4 * i));
        for (int i = 0; i < n_val; i++) begin
            sidx_q.push_back(8'(i));
            sdat_q.push_back(dmem[i]);
        end
        scan_req = 1'b1;
        tick(1);
        scan_req = 1'b0;
        if (halt_at == 0) begin
            tick(SCAN_WORDS + 2);
        end else begin
            tick(halt_at - 1);
            halt_req = 1'b1;
            tick(1);
            halt_req = 1'b0;
            tick(2);
        end
        end_check();
    endtask

    task automatic chk_reset_outputs();
        chk("rst_state", state, 0);
        chk("rst_clk_en", cpu_clk_en, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, bus.cpu_addr);
        chk("rst_scan_valid", bus.scan_valid, 0);
        chk("rst_scan_idx", bus.scan_idx, 0);
        chk("rst_cycle_count", cycle_count, 0);
        chk("rst_cycle_count_narrow", cycle_count2, 0);
        chk("rst_bp_hit", bp_hit, 0);
    endtask

    task automatic release_reset();
        model_cnt  = 32'd0;
        model_cnt4 = 0;
        model_bp   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick(1);
        end_check();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) dmem[i] = 32'h100 + 32'(i);
        #1;
        rst = 1'b0;
        #1;
        chk_reset_outputs();
        release_reset();

        // Free run, breakpoint stop and resume.
        do_run(10, 1'b0, 1'b0);
        do_bp(4);
        do_run(3, 1'b0, 1'b0);
        bp_en = 1'b0;

        // Single steps, one with a repeated request inside STEP, one with a
        // breakpoint sitting on the current PC.
        do_step(1'b0);
        tick(2);
        do_step(1'b1);
        bp_en = 1'b1;
        bp_pc = model_pc;
        do_step(1'b0);
        bp_en = 1'b0;

        // Full sweep and an abort in the third scan cycle.
        do_scan(0);
        do_scan(3);

        // Halt with run held, run+scan together, clr during RUN.
        do_run_halt(5);
        do_run(4, 1'b1, 1'b1);

        // Clear in IDLE, then saturate the narrow counter.
        clr_count = 1'b1;
        tick(1);
        clr_count = 1'b0;
        model_cnt  = 32'd0;
        model_cnt4 = 0;
        tick(1);
        end_check();
        do_run(20, 1'b0, 1'b0);

        // Asynchronous reset in the middle of RUN.
        run_req = 1'b1;
        add_en(2);
        tick(3);
        #2;
        rst = 1'b0;
        run_req = 1'b0;
        #1;
        chk_reset_outputs();
        release_reset();

        // Asynchronous reset in the middle of a scan.
        addr_q.push_back(32'd0);
        addr_q.push_back(32'd4);
        sidx_q.push_back(8'd0);
        sdat_q.push_back(dmem[0]);
        scan_req = 1'b1;
        tick(1);
        scan_req = 1'b0;
        tick(2);
        chk("scan_valid_pre_rst", bus.scan_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outputs();
        release_reset();

        // Randomized mix of operations.
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 5))
                0: begin
                    bp_en = 1'($urandom);
                    bp_pc = model_pc - 32'd4;
                    do_run($urandom_range(1, 12), 1'($urandom), 1'($urandom));
                end
                1: begin
                    bp_en = 1'($urandom);
                    bp_pc = model_pc;
                    do_step(1'($urandom));
                end
                2: begin
                    for (int i = 0; i < SCAN_WORDS; i++) dmem[i] = $urandom;
                    do_scan(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, SCAN_WORDS));
                end
                3: begin
                    bp_en = 1'b0;
                    do_run_halt($urandom_range(1, 8));
                end
                4: begin
                    do_bp($urandom_range(1, 6));
                    do_run($urandom_range(1, 5), 1'b0, 1'b0);
                end
                default: begin
                    clr_count = 1'b1;
                    tick(1);
                    clr_count = 1'b0;
                    model_cnt  = 32'd0;
                    model_cnt4 = 0;
                    tick(1);
                    end_check();
                end
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_run_ctrl.md
# pipeline_run_ctrl

Run/step/breakpoint controller for the five-stage RISC-V pipeline. It generates the pipeline's clock-enable and counts executed cycles. It also arbitrates the data-memory address port between the CPU's EX-stage ALU result and a readout scanner that sweeps data memory for the 7-segment display while the core is frozen. It sits between the board inputs (keys/switches), the pipeline stage registers, and the data-memory address mux.

## Interface
- SCAN_WORDS, 8: number of data-memory words swept in one scan (1..256).
- CNT_W, 32: width of the executed-cycle counter.
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-low reset.
- run_req  in  1  level; request free-running execution.
- step_req  in  1  one-cycle pulse; request a single pipeline advance.
- halt_req  in  1  level; stop execution or abort a scan.
- scan_req  in  1  one-cycle pulse; start a data-memory sweep.
- clr_count  in  1  pulse; clear cycle_count (honoured in IDLE only).
- bp_en  in  1  breakpoint enable.
- bp_pc  in  32  breakpoint PC.
- pc_in  in  32  current IF-stage PC.
- cpu_addr  in  32  EX-stage ALU result (CPU data address).
- cpu_we  in  1  CPU data-memory write strobe.
- cpu_clk_en  out  1  pipeline advance enable; all stage registers update only when 1.
- mem_addr  out  32  data-memory address.
- mem_we  out  1  gated data-memory write.
- scan_idx  out  8  word index of the data currently valid.
- scan_valid  out  1  data memory read output corresponds to scan_idx.
- cycle_count  out  CNT_W  number of cycles with cpu_clk_en=1.
- state  out  2  IDLE=0, RUN=1, STEP=2, SCAN=3.
- bp_hit  out  1  sticky; last stop was caused by the breakpoint.

## Operation
- FSM states IDLE, RUN, STEP, SCAN; registered state, combinational cpu_clk_en.
- IDLE: cpu_clk_en=0. Transition priority: run_req → RUN, else step_req → STEP, else scan_req → SCAN. halt_req held forces IDLE to stay IDLE.
- RUN:
  - bp_match = bp_en & (pc_in == bp_pc) & ~first_run. first_run is 1 only in the first cycle after entering RUN, so execution can resume from a breakpoint.
  - stop = halt_req | ~run_req | bp_match.
  - cpu_clk_en = ~stop. The stop cycle itself does not advance, so the core freezes with pc_in == bp_pc.
  - Next state is IDLE on stop. bp_hit is set on bp_match and cleared on the next entry into RUN or STEP.
- STEP: cpu_clk_en=1 for exactly one cycle, then unconditionally IDLE. step_req pulses arriving during STEP are ignored; breakpoints are ignored.
- SCAN:
  - cpu_clk_en=0. mem_addr = {scan_ptr, 2'b00}, with scan_ptr counting 0..SCAN_WORDS-1, one per cycle.
  - scan_idx/scan_valid are scan_ptr/1 delayed one cycle, matching the synchronous memory read latency.
  - After scan_ptr = SCAN_WORDS-1 is issued, go to IDLE. scan_valid for the last word is asserted in the first IDLE cycle.
  - halt_req aborts to IDLE immediately; no further scan_valid is asserted.
- Arbitration: mem_addr = cpu_addr in every state except SCAN. mem_we = cpu_we & cpu_clk_en, so stores never commit while frozen or scanning.
- cycle_count: +1 on each cycle with cpu_clk_en=1; saturates at all-ones. clr_count clears it only in IDLE; otherwise clr_count is ignored.

## Timing
- Reset (rst low, async): state=IDLE, cpu_clk_en=0, mem_we=0, mem_addr=cpu_addr, scan_idx=0, scan_valid=0, cycle_count=0, bp_hit=0, scan_ptr=0.
- Request to first enable: 1 cycle (request sampled in IDLE; cpu_clk_en high the next cycle).
- halt_req/breakpoint to freeze: 0 cycles (combinational gate in the same cycle).
- Scan: first scan_valid 2 cycles after the scan_req edge. SCAN_WORDS consecutive valid cycles; SCAN_WORDS+1 cycles until return to IDLE state observation.
- Simultaneous events:
  - run_req and scan_req in IDLE → RUN.
  - halt_req and run_req in RUN → stop.
  - clr_count during RUN → ignored.
  - Reset mid-scan → IDLE, scan_valid drops asynchronously.
- cycle_count at saturation stays all-ones while enabled.

## Test plan
- Reset, run_req=1 for 10 cycles, then run_req=0 → cpu_clk_en high exactly 10 cycles, cycle_count=10, state returns to 0.
- bp_en=1, bp_pc=0x10, with the PC incrementing by 4 per enabled cycle from 0 → freezes with pc_in=0x10, cycle_count=4, bp_hit=1. Re-asserting run_req advances past 0x10, and bp_hit clears.
- Three step_req pulses spaced 3 cycles apart → exactly 3 single-cycle cpu_clk_en pulses, cycle_count=3. A step_req during STEP is ignored.
- SCAN_WORDS=8, scan_req with memory word i = 0x100+i → scan_valid for 8 consecutive cycles with scan_idx 0..7 and data 0x100..0x107. mem_addr sequence is 0x0..0x1C. cpu_we=1 throughout gives mem_we=0.
- halt_req at the 3rd scan cycle → scan_valid stops after idx 1, state=0 next cycle.
- Assert rst low mid-RUN → all outputs at reset values immediately. Preload the counter near max (CNT_W=4): 20 enabled cycles → cycle_count=15.
